// File: rtl/sprite_vram_pkg.sv
// -----------------------------------------------------------------------------
// sprite_vram_pkg
// Shared widths, DMA state encoding and timing constants for the sprite VRAM
// controller slice (sprite_vram_ctrl and its DMA engine sprite_vram_dma).
//
// Contents:
//   WADDR_W_DEF / RADDR_W_DEF / DATA_W_DEF / LINE_W_DEF : default port widths
//   DMA_LEN_W    : width of the dma_len word-count port
//   DMA_MAX_LEN  : largest transfer the engine performs (longer requests clamp)
//   LINE_LATENCY : cycles from line_req_valid to line_data_valid
//   dma_state_t  : DMA FSM state encoding
//   clamp_len()  : saturates a requested word count to DMA_MAX_LEN
// -----------------------------------------------------------------------------
package sprite_vram_pkg;

    localparam int WADDR_W_DEF  = 15;
    localparam int RADDR_W_DEF  = 12;
    localparam int DATA_W_DEF   = 16;
    localparam int LINE_W_DEF   = 128;
    localparam int DMA_LEN_W    = 16;
    localparam int LINE_LATENCY = 2;

    localparam logic [DMA_LEN_W-1:0] DMA_MAX_LEN = 16'h8000;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_RUN  = 2'd1,
        DMA_DONE = 2'd2
    } dma_state_t;

    // A 32768-word transfer covers the whole pixel-pair space exactly once,
    // so anything longer would only rewrite words already written.
    function automatic logic [DMA_LEN_W-1:0] clamp_len(input logic [DMA_LEN_W-1:0] len);
        return (len > DMA_MAX_LEN) ? DMA_MAX_LEN : len;
    endfunction

endpackage

// File: rtl/sprite_vram_dma.sv
// -----------------------------------------------------------------------------
// sprite_vram_dma
// DMA engine for the sprite VRAM controller: a three-state FSM (IDLE, RUN,
// DONE), the destination address counter and the remaining-word counter.
// The engine does not see the VRAM itself; the top arbitrates and tells it
// when one of its words has been accepted.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   dma_start     : start pulse, honoured only in IDLE
//   dma_base      : first destination word address (latched on start)
//   dma_len       : word count (latched on start, clamped to DMA_MAX_LEN)
//   word_accept   : one DMA word transferred into the write register this cycle
//   dma_run       : FSM is in RUN (may request the write port)
//   dma_addr      : destination address of the next word
//   dma_busy      : high in RUN and DONE
//   dma_done      : one-cycle completion pulse (DONE state)
// -----------------------------------------------------------------------------
module sprite_vram_dma
    import sprite_vram_pkg::*;
#(
    parameter int WADDR_W = WADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dma_start,
    input  logic [WADDR_W-1:0]   dma_base,
    input  logic [DMA_LEN_W-1:0] dma_len,
    input  logic                 word_accept,
    output logic                 dma_run,
    output logic [WADDR_W-1:0]   dma_addr,
    output logic                 dma_busy,
    output logic                 dma_done
);

    dma_state_t             state_reg, state_next;
    logic [WADDR_W-1:0]     addr_reg;
    logic [DMA_LEN_W-1:0]   remain_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DMA_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DMA_IDLE: begin
                // A zero-length request still reports completion.
                if (dma_start) begin
                    state_next = (dma_len == '0) ? DMA_DONE : DMA_RUN;
                end
            end
            DMA_RUN: begin
                if (word_accept && (remain_reg == DMA_LEN_W'(1))) begin
                    state_next = DMA_DONE;
                end
            end
            DMA_DONE: begin
                state_next = DMA_IDLE;
            end
            default: begin
                state_next = DMA_IDLE;
            end
        endcase
    end

    // Address wraps modulo 2^WADDR_W through natural overflow of the adder.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg   <= '0;
            remain_reg <= '0;
        end else if ((state_reg == DMA_IDLE) && dma_start) begin
            addr_reg   <= dma_base;
            remain_reg <= clamp_len(dma_len);
        end else if ((state_reg == DMA_RUN) && word_accept) begin
            addr_reg   <= addr_reg + 1'b1;
            remain_reg <= remain_reg - 1'b1;
        end
    end

    assign dma_run  = (state_reg == DMA_RUN);
    assign dma_busy = (state_reg == DMA_RUN) || (state_reg == DMA_DONE);
    assign dma_done = (state_reg == DMA_DONE);
    assign dma_addr = addr_reg;

endmodule

// File: rtl/sprite_vram_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_vram_ctrl
// Front end of a dual-port sprite VRAM (external block RAM). The single write
// port is shared round-robin between an MCU write channel and a DMA engine;
// the read port serves sprite-line fetches with a fixed two-cycle latency.
//
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   mcu_wr_valid/ready/addr/data       : MCU word writes (valid/ready handshake)
//   dma_start/base/len, dma_busy/done  : DMA transfer control and status
//   dma_in_valid/ready/data            : DMA source word stream
//   vram_write_addr/data/enable        : registered BRAM write port
//   line_req_valid/addr                : sprite-line read request (always taken)
//   vram_read_addr, vram_read_data     : BRAM read port (registered read in BRAM)
//   line_data_valid, line_data         : returned sprite line
// -----------------------------------------------------------------------------
module sprite_vram_ctrl
    import sprite_vram_pkg::*;
#(
    parameter int WADDR_W = WADDR_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LINE_W  = LINE_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 mcu_wr_valid,
    output logic                 mcu_wr_ready,
    input  logic [WADDR_W-1:0]   mcu_wr_addr,
    input  logic [DATA_W-1:0]    mcu_wr_data,

    input  logic                 dma_start,
    input  logic [WADDR_W-1:0]   dma_base,
    input  logic [DMA_LEN_W-1:0] dma_len,
    output logic                 dma_busy,
    output logic                 dma_done,

    input  logic                 dma_in_valid,
    output logic                 dma_in_ready,
    input  logic [DATA_W-1:0]    dma_in_data,

    output logic [WADDR_W-1:0]   vram_write_addr,
    output logic [DATA_W-1:0]    vram_write_data,
    output logic                 vram_write_enable,

    input  logic                 line_req_valid,
    input  logic [RADDR_W-1:0]   line_req_addr,
    output logic [RADDR_W-1:0]   vram_read_addr,
    input  logic [LINE_W-1:0]    vram_read_data,
    output logic                 line_data_valid,
    output logic [LINE_W-1:0]    line_data
);

    // ------------------------------------------------------------------
    // DMA engine
    // ------------------------------------------------------------------
    logic               dma_run;
    logic [WADDR_W-1:0] dma_addr;
    logic               dma_grant;

    sprite_vram_dma #(
        .WADDR_W (WADDR_W)
    ) u_dma (
        .clk         (clk),
        .reset       (reset),
        .dma_start   (dma_start),
        .dma_base    (dma_base),
        .dma_len     (dma_len),
        .word_accept (dma_grant),
        .dma_run     (dma_run),
        .dma_addr    (dma_addr),
        .dma_busy    (dma_busy),
        .dma_done    (dma_done)
    );

    // ------------------------------------------------------------------
    // Write-port arbitration
    // A requester is pending only when it has a word to hand over, so a
    // grant is always a transfer. The pointer moves only on a tie and then
    // favours the loser, so a lone requester never costs the other a turn.
    // ------------------------------------------------------------------
    logic mcu_req;
    logic dma_req;
    logic mcu_grant;
    logic rr_dma_first_reg;

    always_comb begin
        mcu_req   = mcu_wr_valid;
        dma_req   = dma_run && dma_in_valid;
        mcu_grant = mcu_req && (!dma_req || !rr_dma_first_reg);
        dma_grant = dma_req && (!mcu_req ||  rr_dma_first_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_dma_first_reg <= 1'b0;
        end else if (mcu_req && dma_req) begin
            rr_dma_first_reg <= mcu_grant;
        end
    end

    assign mcu_wr_ready = mcu_grant;
    assign dma_in_ready = dma_grant;

    // ------------------------------------------------------------------
    // Registered write port: addr/data hold their last value when idle,
    // only the enable drops.
    // ------------------------------------------------------------------
    logic               wr_en_reg;
    logic [WADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0]  wr_data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= mcu_grant || dma_grant;
            if (mcu_grant) begin
                wr_addr_reg <= mcu_wr_addr;
                wr_data_reg <= mcu_wr_data;
            end else if (dma_grant) begin
                wr_addr_reg <= dma_addr;
                wr_data_reg <= dma_in_data;
            end
        end
    end

    assign vram_write_enable = wr_en_reg;
    assign vram_write_addr   = wr_addr_reg;
    assign vram_write_data   = wr_data_reg;

    // ------------------------------------------------------------------
    // Line read pipeline: one cycle for the address register here, one for
    // the BRAM's registered read. No forwarding from the write port; a
    // same-cycle collision returns whatever the BRAM's read mode gives.
    // ------------------------------------------------------------------
    logic [RADDR_W-1:0]      rd_addr_reg;
    logic [LINE_LATENCY-1:0] rd_vld_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_reg <= '0;
        end else if (line_req_valid) begin
            rd_addr_reg <= line_req_addr;
        end
    end

    generate
        for (genvar gi = 0; gi < LINE_LATENCY; gi++) begin : g_rd_vld
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) begin
                        rd_vld_reg[gi] <= 1'b0;
                    end else begin
                        rd_vld_reg[gi] <= line_req_valid;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) begin
                        rd_vld_reg[gi] <= 1'b0;
                    end else begin
                        rd_vld_reg[gi] <= rd_vld_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign vram_read_addr  = rd_addr_reg;
    assign line_data_valid = rd_vld_reg[LINE_LATENCY-1];
    assign line_data       = vram_read_data;

endmodule

// File: tb/tb_sprite_vram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_vram_ctrl
// Directed self-checking bench for sprite_vram_ctrl. Inputs change just after
// the falling edge; registered outputs are observed there too, combinational
// readies 1 ns after the inputs settle. A small BRAM read model supplies
// vram_read_data from a fixed per-address pattern.
// -----------------------------------------------------------------------------
module tb_sprite_vram_ctrl;

    logic          clk;
    logic          reset;
    logic          mcu_wr_valid;
    logic          mcu_wr_ready;
    logic [14:0]   mcu_wr_addr;
    logic [15:0]   mcu_wr_data;
    logic          dma_start;
    logic [14:0]   dma_base;
    logic [15:0]   dma_len;
    logic          dma_busy;
    logic          dma_done;
    logic          dma_in_valid;
    logic          dma_in_ready;
    logic [15:0]   dma_in_data;
    logic [14:0]   vram_write_addr;
    logic [15:0]   vram_write_data;
    logic          vram_write_enable;
    logic          line_req_valid;
    logic [11:0]   line_req_addr;
    logic [11:0]   vram_read_addr;
    logic [127:0]  vram_read_data;
    logic          line_data_valid;
    logic [127:0]  line_data;

    int total;
    int bad;

    sprite_vram_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .mcu_wr_valid      (mcu_wr_valid),
        .mcu_wr_ready      (mcu_wr_ready),
        .mcu_wr_addr       (mcu_wr_addr),
        .mcu_wr_data       (mcu_wr_data),
        .dma_start         (dma_start),
        .dma_base          (dma_base),
        .dma_len           (dma_len),
        .dma_busy          (dma_busy),
        .dma_done          (dma_done),
        .dma_in_valid      (dma_in_valid),
        .dma_in_ready      (dma_in_ready),
        .dma_in_data       (dma_in_data),
        .vram_write_addr   (vram_write_addr),
        .vram_write_data   (vram_write_data),
        .vram_write_enable (vram_write_enable),
        .line_req_valid    (line_req_valid),
        .line_req_addr     (line_req_addr),
        .vram_read_addr    (vram_read_addr),
        .vram_read_data    (vram_read_data),
        .line_data_valid   (line_data_valid),
        .line_data         (line_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] line_pat(input logic [11:0] a);
        logic [15:0] w;
        w = {4'h0, a} ^ 16'hC3A5;
        return {8{w}};
    endfunction

    // BRAM read port model: registered read.
    always @(posedge clk) vram_read_data <= line_pat(vram_read_addr);

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        total++; if (vram_write_enable !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", vram_write_enable); end
        total++; if (vram_write_addr !== 15'h0) begin bad++; $display("FAIL rst_waddr got=%h want=0", vram_write_addr); end
        total++; if (vram_write_data !== 16'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", vram_write_data); end
        total++; if (vram_read_addr !== 12'h0) begin bad++; $display("FAIL rst_raddr got=%h want=0", vram_read_addr); end
        total++; if (line_data_valid !== 1'b0) begin bad++; $display("FAIL rst_ldv got=%b want=0", line_data_valid); end
        total++; if (dma_busy !== 1'b0 || dma_done !== 1'b0) begin bad++; $display("FAIL rst_dma busy=%b done=%b want 0/0", dma_busy, dma_done); end
        reset = 1'b0;
        tick();
        total++; if (line_data_valid !== 1'b0 || vram_write_enable !== 1'b0) begin bad++; $display("FAIL rst_after ldv=%b we=%b want 0/0", line_data_valid, vram_write_enable); end
        $display("reset: outputs checked");
    endtask

    task automatic test_mcu_write;
        mcu_wr_valid = 1'b1; mcu_wr_addr = 15'h0010; mcu_wr_data = 16'hBEEF;
        #1;
        total++; if (mcu_wr_ready !== 1'b1) begin bad++; $display("FAIL mcu_ready got=%b want=1", mcu_wr_ready); end
        tick();
        mcu_wr_valid = 1'b0;
        total++; if (vram_write_enable !== 1'b1 || vram_write_addr !== 15'h0010 || vram_write_data !== 16'hBEEF) begin
            bad++; $display("FAIL mcu_write got we=%b a=%h d=%h want 1/0010/beef", vram_write_enable, vram_write_addr, vram_write_data);
        end
        tick();
        total++; if (vram_write_enable !== 1'b0) begin bad++; $display("FAIL mcu_we_drop got=%b want=0", vram_write_enable); end
        $display("mcu write: addr=0010 data=beef");
    endtask

    task automatic test_dma_wrap;
        logic [14:0] exp_a [4];
        exp_a[0] = 15'h7FFE; exp_a[1] = 15'h7FFF; exp_a[2] = 15'h0000; exp_a[3] = 15'h0001;
        dma_start = 1'b1; dma_base = 15'h7FFE; dma_len = 16'd4;
        tick();
        dma_start = 1'b0;
        total++; if (dma_busy !== 1'b1) begin bad++; $display("FAIL dma_busy_run got=%b want=1", dma_busy); end
        for (int i = 0; i < 4; i++) begin
            dma_in_valid = 1'b1; dma_in_data = 16'(i + 1);
            #1;
            total++; if (dma_in_ready !== 1'b1 || dma_done !== 1'b0) begin bad++; $display("FAIL dma_ready_%0d ready=%b done=%b want 1/0", i, dma_in_ready, dma_done); end
            tick();
            total++; if (vram_write_enable !== 1'b1 || vram_write_addr !== exp_a[i] || vram_write_data !== 16'(i + 1)) begin
                bad++; $display("FAIL dma_wr_%0d got we=%b a=%h d=%h want 1/%h/%h", i, vram_write_enable, vram_write_addr, vram_write_data, exp_a[i], 16'(i + 1));
            end
            $display("dma write: addr=%h data=%h", vram_write_addr, vram_write_data);
        end
        dma_in_valid = 1'b0;
        total++; if (dma_done !== 1'b1) begin bad++; $display("FAIL dma_done_pulse got=%b want=1", dma_done); end
        tick();
        total++; if (dma_done !== 1'b0 || dma_busy !== 1'b0 || vram_write_enable !== 1'b0) begin
            bad++; $display("FAIL dma_end done=%b busy=%b we=%b want 0/0/0", dma_done, dma_busy, vram_write_enable);
        end
    endtask

    task automatic test_round_robin;
        logic        exp_m;
        logic [14:0] exp_a;
        logic [15:0] exp_d;
        dma_start = 1'b1; dma_base = 15'h0100; dma_len = 16'd3;
        tick();
        dma_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mcu_wr_valid = 1'b1; mcu_wr_addr = 15'(32'h20 + k); mcu_wr_data = 16'(32'h1000 + k);
            dma_in_valid = 1'b1; dma_in_data = 16'(32'h2000 + k);
            exp_m = ((k % 2) == 0);
            #1;
            total++; if (mcu_wr_ready !== exp_m || dma_in_ready !== !exp_m) begin
                bad++; $display("FAIL rr_grant_%0d mcu=%b dma=%b want mcu=%b dma=%b", k, mcu_wr_ready, dma_in_ready, exp_m, !exp_m);
            end
            tick();
            exp_a = exp_m ? 15'(32'h20 + k) : 15'(32'h100 + k / 2);
            exp_d = exp_m ? 16'(32'h1000 + k) : 16'(32'h2000 + k);
            total++; if (vram_write_enable !== 1'b1 || vram_write_addr !== exp_a || vram_write_data !== exp_d) begin
                bad++; $display("FAIL rr_wr_%0d got we=%b a=%h d=%h want 1/%h/%h", k, vram_write_enable, vram_write_addr, vram_write_data, exp_a, exp_d);
            end
            $display("rr write %0d: %s addr=%h data=%h", k, exp_m ? "mcu" : "dma", vram_write_addr, vram_write_data);
        end
        mcu_wr_valid = 1'b0; dma_in_valid = 1'b0;
        total++; if (dma_done !== 1'b1) begin bad++; $display("FAIL rr_done got=%b want=1", dma_done); end
        tick();
        total++; if (dma_busy !== 1'b0) begin bad++; $display("FAIL rr_idle busy=%b want=0", dma_busy); end
    endtask

    task automatic test_len_zero;
        dma_start = 1'b1; dma_base = 15'h0055; dma_len = 16'd0;
        tick();
        dma_start = 1'b0;
        dma_in_valid = 1'b1; dma_in_data = 16'h1234;
        #1;
        total++; if (dma_done !== 1'b1 || dma_busy !== 1'b1 || dma_in_ready !== 1'b0) begin
            bad++; $display("FAIL len0_done done=%b busy=%b ready=%b want 1/1/0", dma_done, dma_busy, dma_in_ready);
        end
        tick();
        dma_in_valid = 1'b0;
        total++; if (dma_done !== 1'b0 || dma_busy !== 1'b0 || vram_write_enable !== 1'b0) begin
            bad++; $display("FAIL len0_end done=%b busy=%b we=%b want 0/0/0", dma_done, dma_busy, vram_write_enable);
        end
        $display("dma len=0: done pulse, no write");
    endtask

    task automatic test_line_reads;
        int          n;
        logic        exp_v;
        logic [11:0] exp_addr;
        for (int i = 0; i < 6; i++) begin
            line_req_valid = (i < 3);
            line_req_addr  = 12'(i + 1);
            tick();
            n = i + 1;
            exp_v = (n >= 2) && (n <= 4);
            exp_addr = 12'(n - 1);
            total++; if (line_data_valid !== exp_v) begin bad++; $display("FAIL line_valid_c%0d got=%b want=%b", n, line_data_valid, exp_v); end
            if (exp_v) begin
                total++; if (line_data !== line_pat(exp_addr)) begin bad++; $display("FAIL line_data_c%0d got=%h want=%h", n, line_data, line_pat(exp_addr)); end
                $display("line read: addr=%h data=%h", exp_addr, line_data);
            end
            if (n == 1) begin
                total++; if (vram_read_addr !== 12'h001) begin bad++; $display("FAIL line_raddr got=%h want=001", vram_read_addr); end
            end
        end
        line_req_valid = 1'b0;
    endtask

    task automatic test_start_ignored;
        dma_start = 1'b1; dma_base = 15'h0200; dma_len = 16'd2;
        tick();
        dma_start = 1'b1; dma_base = 15'h0300; dma_len = 16'd5;
        dma_in_valid = 1'b1; dma_in_data = 16'hAAAA;
        #1;
        total++; if (dma_in_ready !== 1'b1) begin bad++; $display("FAIL ign_ready got=%b want=1", dma_in_ready); end
        tick();
        dma_start = 1'b0; dma_in_data = 16'hBBBB;
        total++; if (vram_write_addr !== 15'h0200 || vram_write_data !== 16'hAAAA) begin
            bad++; $display("FAIL ign_wr0 got a=%h d=%h want 0200/aaaa", vram_write_addr, vram_write_data);
        end
        tick();
        dma_in_valid = 1'b0;
        total++; if (vram_write_addr !== 15'h0201 || vram_write_data !== 16'hBBBB || dma_done !== 1'b1) begin
            bad++; $display("FAIL ign_wr1 got a=%h d=%h done=%b want 0201/bbbb/1", vram_write_addr, vram_write_data, dma_done);
        end
        tick();
        total++; if (dma_busy !== 1'b0 || vram_write_enable !== 1'b0) begin
            bad++; $display("FAIL ign_end busy=%b we=%b want 0/0", dma_busy, vram_write_enable);
        end
        $display("dma restart during run: ignored");
    endtask

    task automatic test_reset_mid_dma;
        dma_start = 1'b1; dma_base = 15'h0400; dma_len = 16'd8;
        tick();
        dma_start = 1'b0;
        dma_in_valid = 1'b1; dma_in_data = 16'h0001;
        tick();
        dma_in_data = 16'h0002;
        line_req_valid = 1'b1; line_req_addr = 12'h007;
        tick();
        total++; if (vram_write_addr !== 15'h0401 || vram_write_enable !== 1'b1) begin
            bad++; $display("FAIL rmid_pre a=%h we=%b want 0401/1", vram_write_addr, vram_write_enable);
        end
        reset = 1'b1; dma_in_valid = 1'b0; line_req_valid = 1'b0;
        tick();
        total++; if (vram_write_enable !== 1'b0 || vram_write_addr !== 15'h0 || vram_write_data !== 16'h0 || vram_read_addr !== 12'h0) begin
            bad++; $display("FAIL rmid_wport we=%b a=%h d=%h ra=%h want 0/0/0/0", vram_write_enable, vram_write_addr, vram_write_data, vram_read_addr);
        end
        total++; if (dma_busy !== 1'b0 || dma_done !== 1'b0 || line_data_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_status busy=%b done=%b ldv=%b want 0/0/0", dma_busy, dma_done, line_data_valid);
        end
        dma_in_valid = 1'b1;
        #1;
        total++; if (dma_in_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b want=0", dma_in_ready); end
        reset = 1'b0;
        tick();
        #1;
        total++; if (dma_done !== 1'b0 || dma_busy !== 1'b0 || dma_in_ready !== 1'b0 || line_data_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_after done=%b busy=%b ready=%b ldv=%b want 0/0/0/0", dma_done, dma_busy, dma_in_ready, line_data_valid);
        end
        dma_in_valid = 1'b0;
        $display("reset during dma: transfer aborted");
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        mcu_wr_valid = 1'b0; mcu_wr_addr = '0; mcu_wr_data = '0;
        dma_start = 1'b0; dma_base = '0; dma_len = '0;
        dma_in_valid = 1'b0; dma_in_data = '0;
        line_req_valid = 1'b0; line_req_addr = '0;
        tick();
        test_reset();
        test_mcu_write();
        test_dma_wrap();
        test_round_robin();
        test_len_zero();
        test_line_reads();
        test_start_ignored();
        test_reset_mid_dma();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_vram_ctrl.md
SPRITE_VRAM_CTRL -- requirements
Module: sprite_vram_ctrl

Interface
REQ-001 SHALL have parameters: WADDR_W, default 15, pixel-pair write address width; RADDR_W, default 12, sprite-line read address width; DATA_W, default 16, write word width; LINE_W, default 128, read line width.
REQ-002 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: mcu_wr_valid  in  1; mcu_wr_ready  out  1; mcu_wr_addr  in  WADDR_W; mcu_wr_data  in  DATA_W.
REQ-004 SHALL have ports: dma_start  in  1  start pulse; dma_base  in  WADDR_W  first word address; dma_len  in  16  word count; dma_busy  out  1; dma_done  out  1  completion pulse.
REQ-005 SHALL have ports: dma_in_valid  in  1; dma_in_ready  out  1; dma_in_data  in  DATA_W  DMA source stream.
REQ-006 SHALL have ports: vram_write_addr  out  WADDR_W; vram_write_data  out  DATA_W; vram_write_enable  out  1.
REQ-007 SHALL have ports: line_req_valid  in  1; line_req_addr  in  RADDR_W; vram_read_addr  out  RADDR_W; vram_read_data  in  LINE_W; line_data_valid  out  1; line_data  out  LINE_W.

Function
REQ-008 SHALL grant the single VRAM write port to at most one requester per cycle: MCU or DMA.
REQ-009 SHALL arbitrate round-robin when both are pending; the loser of a tie wins the next tie; the first tie after reset goes to MCU.
REQ-010 SHALL assert mcu_wr_ready only in a cycle where mcu_wr_valid=1 and MCU holds the grant; a transfer occurs on valid&&ready.
REQ-011 SHALL assert dma_in_ready only in DMA state RUN while DMA holds the grant; a transfer occurs on dma_in_valid&&dma_in_ready.
REQ-012 SHALL register the accepted write: vram_write_enable=1 with that addr/data in the cycle after acceptance, and 0 otherwise.
REQ-013 SHALL implement DMA FSM states IDLE, RUN, DONE: IDLE->RUN on dma_start; RUN->DONE when the last word is accepted; DONE->IDLE after exactly one cycle.
REQ-014 SHALL latch dma_base and dma_len on dma_start in IDLE; dma_start in RUN or DONE SHALL be ignored.
REQ-015 SHALL clamp dma_len above 32768 to 32768; dma_len=0 SHALL go IDLE->DONE with no writes.
REQ-016 SHALL increment the DMA address by 1 per accepted word, wrapping modulo 2^WADDR_W (0x7FFF -> 0x0000).
REQ-017 SHALL drive dma_busy=1 in RUN and DONE, and dma_done=1 only in DONE.
REQ-018 SHALL accept a line request every cycle (no ready): it registers line_req_addr into vram_read_addr in the cycle after line_req_valid.
REQ-019 SHALL assert line_data_valid exactly 2 cycles after line_req_valid, with line_data=vram_read_data passed through; back-to-back requests SHALL return back-to-back in order.
REQ-020 SHALL give no read/write forwarding: a read of a line written in the same cycle returns the BRAM's old-data behaviour.

Reset
REQ-021 SHALL, on reset, drive vram_write_enable=0, vram_write_addr=0, vram_write_data=0, vram_read_addr=0, line_data_valid=0, dma_busy=0, and dma_done=0, set the DMA FSM to IDLE, and set the round-robin pointer to MCU-first.
REQ-022 SHALL, on reset during RUN, abort the transfer with no dma_done pulse; words already issued stay written.
REQ-023 SHALL drop in-flight read valids on reset; line_data_valid SHALL be 0 in the cycle after reset.

Structure
REQ-024 SHALL take widths, the DMA state enum and the line-latency constant (2) from package sprite_vram_pkg.
REQ-025 SHALL place the DMA FSM, address counter and remaining-length counter in sub-module sprite_vram_dma; arbitration and the read pipeline stay in the top.

Verification
REQ-026 SHALL verify: MCU writes addr 0x0010, data 0xBEEF, DMA idle -> mcu_wr_ready the same cycle; next cycle vram_write_enable=1, addr 0x0010, data 0xBEEF.
REQ-027 SHALL verify: dma_base 0x7FFE, dma_len 4, data 1,2,3,4 streamed continuously, no MCU traffic -> writes to 0x7FFE, 0x7FFF, 0x0000, 0x0001; one dma_done pulse; dma_busy=0 after.
REQ-028 SHALL verify: MCU and DMA both valid continuously for 6 cycles -> grants alternate M,D,M,D,M,D.
REQ-029 SHALL verify: dma_len=0 -> dma_done 1 cycle after start; no vram_write_enable.
REQ-030 SHALL verify: line requests 0x001, 0x002, 0x003 on consecutive cycles -> line_data_valid on cycles +2, +3, +4 with matching data; a second dma_start mid-RUN is ignored.
REQ-031 SHALL verify: reset asserted mid-DMA after 2 of 8 words -> FSM IDLE, no dma_done, and outputs at their reset values.
